regfile_wb_arbiter: RTL and testbench

//  Owns the single register-file write port: arbitrates the execute-stage writeback (ex_*) against the

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter (EX vs load return) with pending-load hazard scoreboard.
// Optional feature: define REGFILE_WB_FORWARD_EN for same-cycle load-return forwarding.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    output logic        ex_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        reg_we,
    output logic [4:0]  rd,
    output logic [31:0] rd_value,
    input  logic [4:0]  hz_rs1,
    input  logic [4:0]  hz_rs2,
    input  logic [4:0]  hz_rd,
    output logic        hz_stall,
    output logic        ld_pending,
    input  logic [31:0] rf_rs1_value,
    input  logic [31:0] rf_rs2_value,
    output logic [31:0] rs1_value,
    output logic [31:0] rs2_value
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [31:1] busy;
    logic [31:1] busy_nxt;
    logic [31:1] clr_mask;
    logic [31:0] busy_vec;
    logic [3:0]  wait_cnt;
    logic        ld_grant;
    logic        ex_grant;

    // Grants double as handshakes: ready is only raised for a valid request.
    // Gating with rst_n keeps every write-side strobe low while reset is held.
    assign ld_grant = rst_n & ld_valid & (~ex_valid | (wait_cnt == WAIT_LIMIT));
    assign ex_grant = rst_n & ex_valid & ~ld_grant;
    assign ex_ready = ex_grant;
    assign ld_ready = ld_grant;

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        rd       = '0;
        rd_value = '0;
        if (ld_grant) begin
            rd       = ld_rd;
            rd_value = ld_data;
        end else if (ex_grant) begin
            rd       = ex_rd;
            rd_value = ex_data;
        end
    end

    // x0 requests still consume the grant, they just never reach the regfile.
    assign reg_we = (ld_grant | ex_grant) & (rd != 5'd0);

    // A set in the same cycle as a clear of that register wins.
    always_comb begin
        clr_mask = '0;
        busy_nxt = '0;
        for (int i = 1; i < 32; i++) begin
            clr_mask[i] = ld_grant && (ld_rd == 5'(i));
            busy_nxt[i] = (busy[i] & ~clr_mask[i]) | (ld_issue && (ld_issue_rd == 5'(i)));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            wait_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            if (!ld_valid || ld_grant) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    assign busy_vec   = {busy, 1'b0};
    assign ld_pending = |busy;

`ifdef REGFILE_WB_FORWARD_EN
    logic [31:0] src_busy_vec;

    // Sources freed by this cycle's load return are satisfied by forwarding; the destination is not.
    assign src_busy_vec = {busy & ~clr_mask, 1'b0};
    assign hz_stall     = src_busy_vec[hz_rs1] | src_busy_vec[hz_rs2] | busy_vec[hz_rd];

    always_comb begin
        rs1_value = rf_rs1_value;
        rs2_value = rf_rs2_value;
        if (reg_we && (rd == hz_rs1)) begin
            rs1_value = rd_value;
        end
        if (reg_we && (rd == hz_rs2)) begin
            rs2_value = rd_value;
        end
    end
`else
    assign hz_stall  = busy_vec[hz_rs1] | busy_vec[hz_rs2] | busy_vec[hz_rd];
    assign rs1_value = rf_rs1_value;
    assign rs2_value = rf_rs2_value;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed vectors push expected writebacks, a monitor checks them.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] rd_value;
    logic [4:0]  hz_rs1;
    logic [4:0]  hz_rs2;
    logic [4:0]  hz_rd;
    logic        hz_stall;
    logic        ld_pending;
    logic [31:0] rf_rs1_value;
    logic [31:0] rf_rs2_value;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;

    typedef struct packed {
        logic        exr;
        logic        ldr;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .reg_we(reg_we), .rd(rd), .rd_value(rd_value),
        .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd),
        .hz_stall(hz_stall), .ld_pending(ld_pending),
        .rf_rs1_value(rf_rs1_value), .rf_rs2_value(rf_rs2_value),
        .rs1_value(rs1_value), .rs2_value(rs2_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle out of reset either presents a handshake matching the queue head or none at all.
    always @(negedge clk) begin
        wb_t got;
        wb_t exp;
        if (rst_n && (ex_ready || ld_ready || exp_q.size() != 0)) begin
            got = '{exr: ex_ready, ldr: ld_ready, we: reg_we, rd: rd, val: rd_value};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got exr=%b ldr=%b we=%b rd=%0d val=%h, expected no handshake",
                         got.exr, got.ldr, got.we, got.rd, got.val);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL wb: got exr=%b ldr=%b we=%b rd=%0d val=%h expected exr=%b ldr=%b we=%b rd=%0d val=%h",
                             got.exr, got.ldr, got.we, got.rd, got.val,
                             exp.exr, exp.ldr, exp.we, exp.rd, exp.val);
                end
            end
        end
    end

    task automatic expect_wb(input logic exr, input logic ldr, input logic we,
                             input logic [4:0] r, input logic [31:0] v);
        exp_q.push_back('{exr: exr, ldr: ldr, we: we, rd: r, val: v});
    endtask

    task automatic idle();
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        hz_rs1 = 0; hz_rs2 = 0; hz_rd = 0;
        rf_rs1_value = 32'h1111_1111; rf_rs2_value = 32'hBEEF_BEEF;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 0;
        ex_valid = 1; ex_rd = 5'd7; ld_valid = 1; ld_rd = 5'd8;
        #12;
        check("reset_ex_ready", 32'(ex_ready), 0);
        check("reset_ld_ready", 32'(ld_ready), 0);
        check("reset_reg_we", 32'(reg_we), 0);
        check("reset_ld_pending", 32'(ld_pending), 0);
        idle();
        next_cycle();
        rst_n = 1;
        next_cycle();

        // EX-only writeback lands the same cycle.
        ex_valid = 1; ex_rd = 5'd7; ex_data = 32'h1234;
        expect_wb(1, 0, 1, 5'd7, 32'h1234);
        next_cycle();

        // x0 write consumes the grant without writing; x0 load issue never marks pending.
        idle();
        ex_valid = 1; ex_rd = 5'd0; ex_data = 32'h55;
        ld_issue = 1; ld_issue_rd = 5'd0;
        expect_wb(1, 0, 0, 5'd0, 32'h55);
        next_cycle();
        idle();
        to_neg();
        check("x0_ld_pending", 32'(ld_pending), 0);
        next_cycle();

        // Scoreboard: load to x9 stalls rs1 reader until its return.
        ld_issue = 1; ld_issue_rd = 5'd9;
        next_cycle();
        idle();
        hz_rs1 = 5'd9;
        to_neg();
        check("sb_stall_pending", 32'(hz_stall), 1);
        check("sb_ld_pending", 32'(ld_pending), 1);
        next_cycle();
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h9999;
        expect_wb(0, 1, 1, 5'd9, 32'h9999);
        to_neg();
`ifdef REGFILE_WB_FORWARD_EN
        check("sb_stall_return_cycle", 32'(hz_stall), 0);
        check("sb_fwd_rs1", rs1_value, 32'h9999);
`else
        check("sb_stall_return_cycle", 32'(hz_stall), 1);
        check("sb_fwd_rs1", rs1_value, 32'h1111_1111);
`endif
        next_cycle();
        idle();
        hz_rs1 = 5'd9;
        to_neg();
        check("sb_stall_after_return", 32'(hz_stall), 0);
        check("sb_pending_after_return", 32'(ld_pending), 0);
        next_cycle();

        // Same-cycle set and clear of x9: set wins.
        idle();
        ld_issue = 1; ld_issue_rd = 5'd9;
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'hA9;
        expect_wb(0, 1, 1, 5'd9, 32'hA9);
        next_cycle();
        idle();
        hz_rs1 = 5'd9;
        to_neg();
        check("setclr_busy9", 32'(hz_stall), 1);
        next_cycle();
        idle();
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'hB9;
        expect_wb(0, 1, 1, 5'd9, 32'hB9);
        next_cycle();
        idle();
        to_neg();
        check("setclr_drained", 32'(ld_pending), 0);
        next_cycle();

        // Starvation: ld refused three cycles, granted on the fourth, then ex resumes.
        ex_valid = 1; ex_rd = 5'd10; ex_data = 32'hA;
        ld_valid = 1; ld_rd = 5'd11; ld_data = 32'hB;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) expect_wb(1, 0, 1, 5'd10, 32'hA);
            else       expect_wb(0, 1, 1, 5'd11, 32'hB);
            next_cycle();
        end
        ld_valid = 0;
        expect_wb(1, 0, 1, 5'd10, 32'hA);
        next_cycle();

        // Forwarding of a load return onto rs2.
        idle();
        ld_issue = 1; ld_issue_rd = 5'd3;
        next_cycle();
        idle();
        ld_valid = 1; ld_rd = 5'd3; ld_data = 32'hDEAD;
        hz_rs2 = 5'd3;
        expect_wb(0, 1, 1, 5'd3, 32'hDEAD);
        to_neg();
        check("fwd_rs1_passthrough", rs1_value, 32'h1111_1111);
`ifdef REGFILE_WB_FORWARD_EN
        check("fwd_rs2_value", rs2_value, 32'hDEAD);
        check("fwd_hz_stall", 32'(hz_stall), 0);
`else
        check("fwd_rs2_value", rs2_value, 32'hBEEF_BEEF);
        check("fwd_hz_stall", 32'(hz_stall), 1);
`endif
        next_cycle();

        // A returning load's destination still stalls a WAW issue.
        idle();
        ld_issue = 1; ld_issue_rd = 5'd12;
        next_cycle();
        idle();
        ld_valid = 1; ld_rd = 5'd12; ld_data = 32'hC;
        hz_rd = 5'd12;
        expect_wb(0, 1, 1, 5'd12, 32'hC);
        to_neg();
        check("waw_hz_rd_stall", 32'(hz_stall), 1);
        next_cycle();

        // Reset mid-run with busy[5]=1 and wait_cnt=2.
        idle();
        ld_issue = 1; ld_issue_rd = 5'd5;
        next_cycle();
        idle();
        ex_valid = 1; ex_rd = 5'd13; ex_data = 32'hD;
        ld_valid = 1; ld_rd = 5'd14; ld_data = 32'hE;
        hz_rs1 = 5'd5;
        for (int i = 0; i < 2; i++) begin
            expect_wb(1, 0, 1, 5'd13, 32'hD);
            next_cycle();
        end
        rst_n = 0;
        #1;
        check("midrst_ex_ready", 32'(ex_ready), 0);
        check("midrst_ld_ready", 32'(ld_ready), 0);
        check("midrst_reg_we", 32'(reg_we), 0);
        check("midrst_hz_stall", 32'(hz_stall), 0);
        check("midrst_ld_pending", 32'(ld_pending), 0);
        next_cycle();
        rst_n = 1;
        // wait_cnt restarted from 0: three ex grants before the load wins.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) expect_wb(1, 0, 1, 5'd13, 32'hD);
            else       expect_wb(0, 1, 1, 5'd14, 32'hE);
            next_cycle();
        end
        idle();
        next_cycle();
        next_cycle();

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
